// File: rtl/spi_slave_rx_if.sv
// SPI receive-side bundle: the three master-driven lines plus the
// word/status outputs of the receiver.
interface spi_slave_rx_if #(
    parameter int DATA_W = 8
);
    logic              cs;
    logic              scl;
    logic              sda;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              busy;
    logic              frame_err;
    logic [7:0]        byte_cnt;

    // The SPI master drives the lines and observes the receiver status.
    modport master (
        output cs, scl, sda,
        input  data_out, valid, busy, frame_err, byte_cnt
    );

    // The receiver consumes the lines and produces the status.
    modport slave (
        input  cs, scl, sda,
        output data_out, valid, busy, frame_err, byte_cnt
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes cs/scl/sda into clk, rebuilds MSB-first
// words, strobes valid per word and flags frames aborted mid-word.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter bit SAMPLE_RISE = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    spi_slave_rx_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronizer chains (s3 only where an edge is needed).
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic scl_s1_q, scl_s2_q, scl_s3_q;
    logic sda_s1_q, sda_s2_q;

    // Receiver state.
    state_t            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;

    // After reset the sync chains hold the idle level 1 for two cycles, so a
    // cs held low through reset would look like a fresh fall. settle counts
    // those cycles; armed is set only once a genuine high cs is observed.
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;

    logic sample_edge;
    logic cs_rise;

    assign sample_edge = SAMPLE_RISE ? (scl_s2_q & ~scl_s3_q) : (~scl_s2_q & scl_s3_q);
    assign cs_rise     = cs_s2_q & ~cs_s3_q;

    // Next-state logic for the frame/word assembly state machine.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        frame_err_d = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        settle_d    = settle_q;
        armed_d     = armed_q;

        if (settle_q != 2'd2) begin
            settle_d = settle_q + 2'd1;
        end
        if ((settle_q == 2'd2) && cs_s2_q) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !cs_s2_q) begin
                    state_d    = ST_SHIFT;
                    sr_d       = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = 8'd0;
                    busy_d     = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A cs rise wins over a coincident sample edge.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    sr_d = {sr_q[DATA_W-2:0], sda_s2_q};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        data_out_d = sr_d;
                        valid_d    = 1'b1;
                        bit_cnt_d  = '0;
                        byte_cnt_d = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All registers: sync chains reset to idle-high, everything else to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_s3_q     <= 1'b1;
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            scl_s3_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            byte_cnt_q  <= 8'd0;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            cs_s1_q     <= bus.cs;
            cs_s2_q     <= cs_s1_q;
            cs_s3_q     <= cs_s2_q;
            scl_s1_q    <= bus.scl;
            scl_s2_q    <= scl_s1_q;
            scl_s3_q    <= scl_s2_q;
            sda_s1_q    <= bus.sda;
            sda_s2_q    <= sda_s1_q;
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            byte_cnt_q  <= byte_cnt_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: one rising-edge and one falling-edge receiver,
// each driven by its own SPI line set, checked through a word scoreboard.
module tb_spi_slave_rx;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [1:0] cs_l  = 2'b11;
    logic [1:0] scl_l = 2'b00;
    logic [1:0] sda_l = 2'b00;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: {receiver index, word} in expected arrival order.
    logic [8:0] expq[$];
    logic [8:0] mon_e;
    int         ferr_exp [2];
    logic [7:0] last_word [2];

    spi_slave_rx_if #(.DATA_W(8)) b0 ();
    spi_slave_rx_if #(.DATA_W(8)) b1 ();

    assign b0.cs  = cs_l[0];
    assign b0.scl = scl_l[0];
    assign b0.sda = sda_l[0];
    assign b1.cs  = cs_l[1];
    assign b1.scl = scl_l[1];
    assign b1.sda = sda_l[1];

    spi_slave_rx #(.DATA_W(8), .SAMPLE_RISE(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    spi_slave_rx #(.DATA_W(8), .SAMPLE_RISE(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    logic [1:0] valid_w, busy_w, ferr_w;
    logic [7:0] dout_w [2];
    logic [7:0] bcnt_w [2];
    assign valid_w   = {b1.valid, b0.valid};
    assign busy_w    = {b1.busy, b0.busy};
    assign ferr_w    = {b1.frame_err, b0.frame_err};
    assign dout_w[0] = b0.data_out;
    assign dout_w[1] = b1.data_out;
    assign bcnt_w[0] = b0.byte_cnt;
    assign bcnt_w[1] = b1.byte_cnt;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One serial bit. Receiver 0 (rising sample): data set in the low phase.
    // Receiver 1 (falling sample): data changes with the rising scl edge.
    task automatic drive_bit(input int s, input logic b, input int half);
        if (s == 0) begin
            sda_l[0] = b;
            wait_cyc(half);
            scl_l[0] = 1'b1;
            wait_cyc(half);
            scl_l[0] = 1'b0;
        end else begin
            scl_l[1] = 1'b1;
            sda_l[1] = b;
            wait_cyc(half);
            scl_l[1] = 1'b0;
            wait_cyc(half);
        end
    endtask

    // One cs-low frame: whole bytes followed by an optional partial word.
    task automatic send_frame(input int s, input logic [7:0] bytes[$], input int npart,
                              input logic [7:0] part, input int half);
        int nb;
        nb = bytes.size();
        foreach (bytes[k]) begin
            expq.push_back({s[0], bytes[k]});
            last_word[s] = bytes[k];
        end
        if (npart > 0) ferr_exp[s]++;
        cs_l[s] = 1'b0;
        wait_cyc(4);
        check("busy_in_frame", {31'd0, busy_w[s]}, 1);
        foreach (bytes[k]) begin
            for (int i = 7; i >= 0; i--) drive_bit(s, bytes[k][i], half);
        end
        for (int i = 0; i < npart; i++) drive_bit(s, part[7-i], half);
        wait_cyc(half);
        cs_l[s] = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_before_3rd_edge", {31'd0, busy_w[s]}, 1);
        @(negedge clk);
        check("busy_fall_3rd_edge", {31'd0, busy_w[s]}, 0);
        wait_cyc(4);
        check("byte_cnt", {24'd0, bcnt_w[s]}, (nb > 255) ? 255 : nb);
        check("data_out_held", {24'd0, dout_w[s]}, {24'd0, last_word[s]});
    endtask

    // Monitor: pops the scoreboard on every valid strobe.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (valid_w[s]) begin
                if (expq.size() == 0) begin
                    check("valid_unexpected", {31'd0, valid_w[s]}, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("word", {23'd0, s[0], dout_w[s]}, {23'd0, mon_e});
                end
            end
            if (ferr_w[s]) begin
                if (ferr_exp[s] == 0) check("frame_err_unexpected", {31'd0, ferr_w[s]}, 0);
                else ferr_exp[s]--;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int s, n, np, half;

        ferr_exp[0] = 0;
        ferr_exp[1] = 0;
        last_word[0] = 8'h00;
        last_word[1] = 8'h00;

        #3 reset = 1'b1;
        wait_cyc(3);
        for (int i = 0; i < 2; i++) begin
            check("rst_data_out", {24'd0, dout_w[i]}, 0);
            check("rst_valid", {31'd0, valid_w[i]}, 0);
            check("rst_busy", {31'd0, busy_w[i]}, 0);
            check("rst_frame_err", {31'd0, ferr_w[i]}, 0);
            check("rst_byte_cnt", {24'd0, bcnt_w[i]}, 0);
        end
        reset = 1'b0;
        wait_cyc(8);

        // scl activity with cs high is ignored by both receivers.
        for (int i = 0; i < 16; i++) begin
            scl_l = ~scl_l;
            sda_l = 2'($urandom);
            wait_cyc(3);
        end
        scl_l = 2'b00;
        wait_cyc(6);
        check("idle_byte_cnt0", {24'd0, bcnt_w[0]}, 0);
        check("idle_byte_cnt1", {24'd0, bcnt_w[1]}, 0);

        // Single mode-0 byte.
        q = '{8'hE2};
        send_frame(0, q, 0, 8'h00, 10);

        // Back-to-back bytes in one frame.
        q = '{8'hA5, 8'h3C, 8'hFF};
        send_frame(0, q, 0, 8'h00, 10);

        // Good byte then abort after 5 bits.
        q = '{8'h55};
        send_frame(0, q, 5, 8'h81, 6);

        // Falling-edge receiver.
        q = '{8'hC3};
        send_frame(1, q, 0, 8'h00, 5);

        // Minimum scl phases with valid latency measured on the last bit.
        last_word[0] = 8'h96;
        expq.push_back({1'b0, 8'h96});
        cs_l[0] = 1'b0;
        wait_cyc(4);
        for (int i = 7; i >= 1; i--) drive_bit(0, q[0][0] ^ q[0][0] ^ 1'b0 | 8'h96 >> i, 3);
        sda_l[0] = 1'b0;
        wait_cyc(3);
        scl_l[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_no_valid_before_3rd", {31'd0, valid_w[0]}, 0);
        @(negedge clk);
        check("lat_valid_3rd_edge", {31'd0, valid_w[0]}, 1);
        check("lat_data_3rd_edge", {24'd0, dout_w[0]}, 32'h96);
        wait_cyc(1);
        scl_l[0] = 1'b0;
        wait_cyc(3);
        cs_l[0] = 1'b1;
        wait_cyc(6);
        check("lat_byte_cnt", {24'd0, bcnt_w[0]}, 1);

        // Reset in the middle of a frame, cs held low through release.
        cs_l[0] = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 4);
        reset = 1'b1;
        #1;
        check("midrst_data_out", {24'd0, dout_w[0]}, 0);
        check("midrst_busy", {31'd0, busy_w[0]}, 0);
        check("midrst_byte_cnt", {24'd0, bcnt_w[0]}, 0);
        check("midrst_data_out1", {24'd0, dout_w[1]}, 0);
        last_word[0] = 8'h00;
        last_word[1] = 8'h00;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(10);
        check("rst_cs_low_not_busy", {31'd0, busy_w[0]}, 0);
        cs_l[0] = 1'b1;
        wait_cyc(6);
        q = '{8'h0F};
        send_frame(0, q, 0, 8'h00, 4);

        // Randomized frames on either receiver.
        for (int f = 0; f < 10; f++) begin
            s    = int'($urandom_range(1, 0));
            n    = int'($urandom_range(3, 0));
            np   = ($urandom_range(1, 0) == 1) ? int'($urandom_range(7, 1)) : 0;
            half = int'($urandom_range(8, 3));
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            send_frame(s, q, np, 8'($urandom), half);
        end

        // Long frame saturates byte_cnt.
        q.delete();
        for (int k = 0; k < 256; k++) q.push_back(8'($urandom));
        send_frame(1, q, 0, 8'h00, 3);

        wait_cyc(10);
        check("scoreboard_drained", expq.size(), 0);
        check("frame_err_seen0", ferr_exp[0], 0);
        check("frame_err_seen1", ferr_exp[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
